// File: rtl/cmd_host_loader.sv
// cmd_host_loader: receives a host command packet into the command RAM, starts
// the executor, waits for it to finish, then streams a status header followed
// by out_len result words read back from the result RAM.
module cmd_host_loader #(
  parameter int AW     = 10,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       rx_data,
  input  logic              rx_valid,
  input  logic              rx_last,
  output logic              rx_ready,
  output logic [AW-1:0]     inram_wr_address,
  output logic              inram_we,
  output logic [15:0]       inram_d,
  output logic              start_exec,
  input  logic              busy,
  input  logic              err,
  input  logic [AW-1:0]     out_len,
  output logic [AW-1:0]     outram_rd_address,
  output logic              outram_re,
  input  logic [15:0]       outram_q,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_RX, S_DROP, S_START, S_WAIT, S_HDR, S_RD, S_RWAIT, S_DATA
  } state_t;

  state_t             state_q, state_d;
  logic [AW:0]        widx_q, widx_d;     // one extra bit flags the 2^AW overflow word
  logic [15:0]        hdr_n_q, hdr_n_d;
  logic [AW-1:0]      ridx_q, ridx_d;
  logic [AW-1:0]      len_q, len_d;
  logic               rx_ready_q, rx_ready_d;
  logic               inram_we_q, inram_we_d;
  logic [AW-1:0]      inram_wr_address_q, inram_wr_address_d;
  logic [15:0]        inram_d_q, inram_d_d;
  logic               start_exec_q, start_exec_d;
  logic               outram_re_q, outram_re_d;
  logic [AW-1:0]      outram_rd_address_q, outram_rd_address_d;
  logic [15:0]        tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               rx_acc, tx_acc, drop_evt;
  logic [AW:0]        idx;
  logic [15:0]        n;
  logic [16:0]        idx_p1;

  // Next-state and next-output logic; every output is registered from the
  // next state so all outputs read 0 straight out of reset.
  always_comb begin
    state_d             = state_q;
    widx_d              = widx_q;
    hdr_n_d             = hdr_n_q;
    ridx_d              = ridx_q;
    len_d               = len_q;
    inram_we_d          = 1'b0;
    inram_wr_address_d  = inram_wr_address_q;
    inram_d_d           = inram_d_q;
    outram_rd_address_d = outram_rd_address_q;
    tx_data_d           = tx_data_q;
    tx_last_d           = tx_last_q;
    drop_cnt_d          = drop_cnt_q;
    drop_evt            = 1'b0;
    rx_acc              = rx_valid && rx_ready_q;
    tx_acc              = tx_valid_q && tx_ready;
    // word0 is judged against its own value before hdr_n is latched
    idx                 = (state_q == S_IDLE) ? '0 : widx_q;
    n                   = (state_q == S_IDLE) ? rx_data : hdr_n_q;
    idx_p1              = 17'(idx) + 17'd1;

    case (state_q)
      S_IDLE, S_RX: begin
        if (rx_acc) begin
          if (state_q == S_IDLE) hdr_n_d = rx_data;
          if (idx[AW] || n < 16'd2) begin
            drop_evt = 1'b1;
            state_d  = rx_last ? S_IDLE : S_DROP;
          end else begin
            inram_we_d         = 1'b1;
            inram_wr_address_d = idx[AW-1:0];
            inram_d_d          = rx_data;
            widx_d             = idx + (AW+1)'(1);
            if (!rx_last)                 state_d = S_RX;
            else if (idx_p1 == {1'b0, n}) state_d = S_START;
            else begin
              drop_evt = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_DROP:  if (rx_acc && rx_last) state_d = S_IDLE;
      S_START: if (busy) state_d = S_WAIT;
      S_WAIT: begin
        if (!busy) begin
          len_d     = out_len;
          tx_data_d = {err, {(15-AW){1'b0}}, out_len};
          tx_last_d = (out_len == '0) || err;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (tx_acc) begin
          tx_last_d = 1'b0;
          if (tx_last_q) state_d = S_IDLE;
          else begin
            ridx_d              = '0;
            outram_rd_address_d = '0;
            state_d             = S_RD;
          end
        end
      end
      S_RD:    state_d = S_RWAIT;
      S_RWAIT: begin
        tx_data_d = outram_q;
        tx_last_d = (ridx_q == len_q - AW'(1));
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (tx_acc) begin
          tx_last_d = 1'b0;
          if (tx_last_q) state_d = S_IDLE;
          else begin
            ridx_d              = ridx_q + AW'(1);
            outram_rd_address_d = ridx_q + AW'(1);
            state_d             = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drop_evt && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);

    rx_ready_d   = state_d inside {S_IDLE, S_RX, S_DROP};
    start_exec_d = (state_d == S_START);
    outram_re_d  = (state_d == S_RD);
    tx_valid_d   = state_d inside {S_HDR, S_DATA};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      widx_q              <= '0;
      hdr_n_q             <= '0;
      ridx_q              <= '0;
      len_q               <= '0;
      rx_ready_q          <= 1'b0;
      inram_we_q          <= 1'b0;
      inram_wr_address_q  <= '0;
      inram_d_q           <= '0;
      start_exec_q        <= 1'b0;
      outram_re_q         <= 1'b0;
      outram_rd_address_q <= '0;
      tx_data_q           <= '0;
      tx_valid_q          <= 1'b0;
      tx_last_q           <= 1'b0;
      drop_cnt_q          <= '0;
    end else begin
      state_q             <= state_d;
      widx_q              <= widx_d;
      hdr_n_q             <= hdr_n_d;
      ridx_q              <= ridx_d;
      len_q               <= len_d;
      rx_ready_q          <= rx_ready_d;
      inram_we_q          <= inram_we_d;
      inram_wr_address_q  <= inram_wr_address_d;
      inram_d_q           <= inram_d_d;
      start_exec_q        <= start_exec_d;
      outram_re_q         <= outram_re_d;
      outram_rd_address_q <= outram_rd_address_d;
      tx_data_q           <= tx_data_d;
      tx_valid_q          <= tx_valid_d;
      tx_last_q           <= tx_last_d;
      drop_cnt_q          <= drop_cnt_d;
    end
  end

  assign rx_ready          = rx_ready_q;
  assign inram_we          = inram_we_q;
  assign inram_wr_address  = inram_wr_address_q;
  assign inram_d           = inram_d_q;
  assign start_exec        = start_exec_q;
  assign outram_re         = outram_re_q;
  assign outram_rd_address = outram_rd_address_q;
  assign tx_data           = tx_data_q;
  assign tx_valid          = tx_valid_q;
  assign tx_last           = tx_last_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: doc/cmd_host_loader.md
Name: cmd_host_loader

Overview:
- Upstream/downstream companion of the command executor.
- Receives a command packet from the host word stream and writes it into the command RAM (inram) from address 0.
- Starts execution, waits for completion, then streams a status header plus out_len result words read back from the result RAM (outram).
- Owns both RAMs' opposite ports: inram write port, outram read port.

Parameters:
- AW, 10, address width of inram/outram.
- DROP_W, 8, width of the saturating dropped-packet counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  16  host command word.
- rx_valid  in  1  rx_data valid.
- rx_last  in  1  final word of packet.
- rx_ready  out  1  loader accepts word (transfer = rx_valid&&rx_ready).
- inram_wr_address  out  AW  command RAM write address.
- inram_we  out  1  command RAM write enable.
- inram_d  out  16  command RAM write data.
- start_exec  out  1  execution request to executor.
- busy  in  1  executor busy.
- err  in  1  executor error flag, valid after busy falls.
- out_len  in  AW  executor result length, valid after busy falls.
- outram_rd_address  out  AW  result RAM read address.
- outram_re  out  1  result RAM read enable; outram_q valid exactly 1 cycle after.
- outram_q  in  16  result RAM read data.
- tx_data  out  16  response word to host.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final response word.
- tx_ready  in  1  host accepts word.
- drop_cnt  out  DROP_W  packets discarded, saturating.

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE. All outputs 0 (rx_ready, inram_we, start_exec, outram_re, tx_valid, tx_last, addresses, data, drop_cnt).
- Packet format: word0 = N, the total word count including word0. Words are written to inram[0..N-1]. Legal N is 2..2^AW.
- IDLE: rx_ready=1, widx=0. First accepted word goes to RX handling.
- RX: every accepted word is written the following cycle (inram_we=1, inram_wr_address=widx, inram_d=word); widx increments; hdr_n is latched from word0. One word per cycle; rx_ready stays 1.
- Packet end: on accepted rx_last with widx+1==hdr_n and hdr_n>=2, go to START.
- Malformed packet: rx_last with a count mismatch, or a word that would make widx reach 2^AW, or hdr_n<2. Go to DROP and increment drop_cnt (saturate at all-ones). Words already written to inram remain, harmless since start_exec is not issued.
- DROP: rx_ready=1; discard words until an accepted rx_last, then return to IDLE. If the overflow word itself carried rx_last, go straight to IDLE.
- START: rx_ready=0. start_exec=1 and held until busy==1 is sampled, then dropped the next cycle. Go to WAIT_DONE.
- WAIT_DONE: wait for busy==0. Then latch err and out_len, and go to TX_HDR.
- TX_HDR: tx_data = {err, (15-AW)'b0, out_len}; tx_valid=1. tx_last=1 iff out_len==0 or err==1. Hold until tx_ready. Then go to IDLE if last, else TX_RD with ridx=0.
- TX_RD: outram_re=1 for one cycle, outram_rd_address=ridx.
- TX_WAIT: capture outram_q into tx_data the next cycle and go to TX_DATA.
- TX_DATA: tx_valid=1, tx_last=(ridx==out_len-1). Hold data stable while tx_ready=0. On accept, ridx++, then go to TX_RD or, if last, IDLE.
- Response throughput: 3 cycles/word minimum.
- tx_valid/tx_data/tx_last never change while tx_valid&&!tx_ready.
- rx_ready=0 in every state from START through the final tx accept. No new packet is accepted while the executor or the response is in flight.
- Reset mid-operation: immediate return to IDLE, start_exec deasserted, any partial response abandoned.

Test Plan:
- Send N=5 {0x0005, 0x0123, 0x8010, 0xABCD, 0x1234} with rx_last on word 4 -> inram[0..4] written at 1 word/cycle; start_exec held until busy=1. Executor model reports busy 20 cycles then err=0, out_len=4 -> header 0x0004 followed by outram[0..3], tx_last on the 4th data word.
- Packet word0=6 but rx_last on word 4 -> no start_exec, drop_cnt=1, next valid packet processed normally.
- Executor ends with err=1, out_len=0 -> single header word 0x8000 with tx_last=1, no outram_re pulses.
- Random tx_ready backpressure (50%) during an 8-word response -> tx_data stable while stalled, all 8 words delivered in order, exactly 8 outram_re pulses.
- Packet longer than 2^AW words with no rx_last -> DROP entered at word 1024, remaining words discarded until rx_last; drop_cnt driven to 255 by 300 bad packets stays at 255.
- rst_n=0 asserted during WAIT_DONE and again during TX_DATA -> all outputs 0 next cycle, state IDLE, rx_ready=1 after release.
